game_controller: RTL and testbench

- Frame-rate game-state controller that sits directly upstream of the display top level.
- Converts raw buttons and the VGA vertical sync into the signed sprite offsets consumed by the transformer instances (logo, head, coin).
- Runs on CLK100MHZ, not on VGA_VS, and treats vsync purely as a synchronized frame tick.
- Outputs change only on frame ticks, so there is no mid-frame tearing.

---
 rtl/game_pkg.sv | 33 +++
 rtl/game_controller_if.sv | 28 ++
 rtl/game_controller_debounce.sv | 44 ++++
 rtl/game_controller.sv | 167 ++++++++++++++++
 tb/tb_game_controller.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the frame-rate game controller.
package game_pkg;

  typedef enum logic [1:0] {
    INTRO_WAIT = 2'd0,
    LOGO_SLIDE = 2'd1,
    HEAD_RISE  = 2'd2,
    PLAY       = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    LEFT   = 2'd0,
    CENTER = 2'd1,
    RIGHT  = 2'd2
  } lane_t;

  localparam logic signed [11:0] COIN_H0     = -12'sd200;
  localparam logic signed [11:0] COIN_V0     = -12'sd40;
  localparam int                 COIN_VSLOPE = 6;

  // Head sits to the right of screen centre when the player is in the left lane.
  function automatic logic signed [11:0] lane_offset(lane_t l, logic signed [11:0] mag);
    logic signed [11:0] off;
    off = 12'sd0;
    case (l)
      LEFT:    off = mag;
      RIGHT:   off = -mag;
      default: off = 12'sd0;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/game_controller_if.sv
// Button/vsync inputs and sprite-offset outputs between the game controller and the display top.
interface game_controller_if;
  import game_pkg::*;

  logic               BTNL;
  logic               BTNR;
  logic               VGA_VS;
  logic               frame_tick;
  state_t             game_state;
  logic signed [11:0] logo_hoff;
  logic signed [11:0] head_hoff;
  logic signed [11:0] head_voff;
  logic signed [11:0] coin_hoff;
  logic signed [11:0] coin_voff;
  logic               coin_valid;

  modport master (
    input  BTNL, BTNR, VGA_VS,
    output frame_tick, game_state, logo_hoff, head_hoff, head_voff,
           coin_hoff, coin_voff, coin_valid
  );

  modport slave (
    output BTNL, BTNR, VGA_VS,
    input  frame_tick, game_state, logo_hoff, head_hoff, head_voff,
           coin_hoff, coin_voff, coin_valid
  );
endinterface

// File: rtl/game_controller_debounce.sv
// Button synchronizer and debouncer: level follows the raw input only after it has been
// stable for DEBOUNCE_CYCLES cycles; btn_press pulses once on each accepted 0->1 change.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic CLK100MHZ,
  input  logic CPU_RESETN,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press
);

  localparam int            CW     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_meta;
  logic          sync_level;
  logic [CW-1:0] count;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sync_meta  <= 1'b0;
      sync_level <= 1'b0;
      count      <= RELOAD;
      btn_level  <= 1'b0;
      btn_press  <= 1'b0;
    end else begin
      sync_meta  <= btn_raw;
      sync_level <= sync_meta;
      btn_press  <= 1'b0;
      // Any cycle matching the accepted level restarts the stability window.
      if (sync_level == btn_level) begin
        count <= RELOAD;
      end else if (count == '0) begin
        btn_level <= sync_level;
        btn_press <= sync_level;
        count     <= RELOAD;
      end else begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/game_controller.sv
// Frame-rate game-state controller: turns buttons and vsync into sprite offsets,
// updating every output only on the synchronized frame tick.
//
// state      | meaning
// INTRO_WAIT | holding the title for the countdown
// LOGO_SLIDE | logo moving left each frame until it reaches its end position
// HEAD_RISE  | head moving up each frame until it reaches the baseline
// PLAY       | lane steering and coin animation; terminal until reset
module game_controller
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 1000000,
  parameter int COUNTDOWN_FRAMES = 45,
  parameter int LOGO_STEP        = 300,
  parameter int LOGO_END         = -600,
  parameter int HEAD_START       = -170,
  parameter int HEAD_STEP        = 170,
  parameter int LANE_OFFSET      = 100,
  parameter int COIN_FRAMES      = 60
) (
  input logic              CLK100MHZ,
  input logic              CPU_RESETN,
  game_controller_if.master bus
);

  localparam int                 CDW         = $clog2(COUNTDOWN_FRAMES + 2);
  localparam logic [CDW-1:0]     CD_RELOAD   = CDW'(COUNTDOWN_FRAMES);
  localparam logic signed [11:0] LOGO_STEP_S = 12'(LOGO_STEP);
  localparam logic signed [11:0] LOGO_END_S  = 12'(LOGO_END);
  localparam logic signed [11:0] HEAD_INIT_S = 12'(HEAD_START);
  localparam logic signed [11:0] HEAD_STEP_S = 12'(HEAD_STEP);
  localparam logic signed [11:0] LANE_OFF_S  = 12'(LANE_OFFSET);
  localparam logic [5:0]         COIN_LAST   = 6'(COIN_FRAMES - 1);

  logic vs_meta, vs_sync, vs_prev, frame_tick;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      vs_meta    <= 1'b0;
      vs_sync    <= 1'b0;
      vs_prev    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vs_meta    <= bus.VGA_VS;
      vs_sync    <= vs_meta;
      vs_prev    <= vs_sync;
      frame_tick <= vs_sync & ~vs_prev;
    end
  end

  logic btnl_level, btnr_level, press_l, press_r;
  logic unused_levels;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .CLK100MHZ (CLK100MHZ),
    .CPU_RESETN(CPU_RESETN),
    .btn_raw   (bus.BTNL),
    .btn_level (btnl_level),
    .btn_press (press_l)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .CLK100MHZ (CLK100MHZ),
    .CPU_RESETN(CPU_RESETN),
    .btn_raw   (bus.BTNR),
    .btn_level (btnr_level),
    .btn_press (press_r)
  );

  assign unused_levels = btnl_level ^ btnr_level;

  state_t             state, state_n;
  lane_t              lane, lane_n;
  logic [CDW-1:0]     countdown, countdown_n;
  logic signed [11:0] logo_hoff_q, logo_n;
  logic signed [11:0] head_hoff_q, head_hoff_n;
  logic signed [11:0] head_voff_q, head_voff_n;
  logic [5:0]         coin_step, step_n;
  logic               coin_valid_q, valid_n;
  logic signed [11:0] logo_sub, head_add;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state        <= INTRO_WAIT;
      lane         <= CENTER;
      countdown    <= CD_RELOAD;
      logo_hoff_q  <= 12'sd0;
      head_hoff_q  <= 12'sd0;
      head_voff_q  <= HEAD_INIT_S;
      coin_step    <= 6'd0;
      coin_valid_q <= 1'b0;
    end else begin
      state        <= state_n;
      lane         <= lane_n;
      countdown    <= countdown_n;
      logo_hoff_q  <= logo_n;
      head_hoff_q  <= head_hoff_n;
      head_voff_q  <= head_voff_n;
      coin_step    <= step_n;
      coin_valid_q <= valid_n;
    end
  end

  always_comb begin
    state_n     = state;
    lane_n      = lane;
    countdown_n = countdown;
    logo_n      = logo_hoff_q;
    head_hoff_n = head_hoff_q;
    head_voff_n = head_voff_q;
    step_n      = coin_step;
    valid_n     = coin_valid_q;
    logo_sub    = logo_hoff_q - LOGO_STEP_S;
    head_add    = head_voff_q + HEAD_STEP_S;

    // Simultaneous left and right presses cancel; presses outside PLAY are dropped.
    if (state == PLAY && (press_l ^ press_r)) begin
      if (press_l) lane_n = (lane == RIGHT) ? CENTER : LEFT;
      else         lane_n = (lane == LEFT)  ? CENTER : RIGHT;
    end

    if (frame_tick) begin
      case (state)
        INTRO_WAIT: begin
          if (countdown == '0) state_n = LOGO_SLIDE;
          else                 countdown_n = countdown - CDW'(1);
        end
        LOGO_SLIDE: begin
          if (logo_sub <= LOGO_END_S) begin
            logo_n  = LOGO_END_S;
            state_n = HEAD_RISE;
          end else begin
            logo_n = logo_sub;
          end
        end
        HEAD_RISE: begin
          if (head_add >= 12'sd0) begin
            head_voff_n = 12'sd0;
            state_n     = PLAY;
          end else begin
            head_voff_n = head_add;
          end
        end
        PLAY: begin
          head_hoff_n = lane_offset(lane, LANE_OFF_S);
          step_n      = (coin_step == COIN_LAST) ? 6'd0 : coin_step + 6'd1;
          valid_n     = 1'b1;
        end
        default: state_n = INTRO_WAIT;
      endcase
    end
  end

  // 59*6 needs 9 bits; product kept at 10 bits before extending to the signed offset.
  logic [9:0] coin_drop;
  assign coin_drop = 10'(coin_step) * 10'(COIN_VSLOPE);

  assign bus.frame_tick = frame_tick;
  assign bus.game_state = state;
  assign bus.logo_hoff  = logo_hoff_q;
  assign bus.head_hoff  = head_hoff_q;
  assign bus.head_voff  = head_voff_q;
  assign bus.coin_hoff  = COIN_H0 + $signed({6'd0, coin_step});
  assign bus.coin_voff  = COIN_V0 - $signed({2'd0, coin_drop});
  assign bus.coin_valid = coin_valid_q;

endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller with a tick-count based behavioural model.
module tb_game_controller;
  import game_pkg::*;

  localparam int DB          = 4;
  localparam int COUNTDOWN   = 45;
  localparam int LOGO_STEP   = 300;
  localparam int LOGO_END    = -600;
  localparam int HEAD_START  = -170;
  localparam int LANE_OFF    = 100;
  localparam int COIN_FRAMES = 60;
  localparam int INTRO_TICKS = COUNTDOWN + 1;    // ticks spent in INTRO_WAIT
  localparam int SLIDE_END   = INTRO_TICKS + 2;  // logo reaches -600 after two steps
  localparam int PLAY_TICK   = SLIDE_END + 1;    // one rise step reaches 0

  logic CLK100MHZ  = 1'b0;
  logic CPU_RESETN = 1'b0;
  always #5 CLK100MHZ = ~CLK100MHZ;

  game_controller_if bus();

  game_controller #(.DEBOUNCE_CYCLES(DB)) dut (
    .CLK100MHZ (CLK100MHZ),
    .CPU_RESETN(CPU_RESETN),
    .bus       (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: outputs are a function of ticks since reset plus the lane seen at each PLAY tick.
  int       m_ticks    = 0;
  int       m_lane     = 1;   // 0 left, 1 centre, 2 right
  int       m_head_off = 0;
  logic     exp_tick   = 1'b0;
  logic [3:0] vs_hist  = '0;

  function automatic int lane_off(input int l);
    return (1 - l) * LANE_OFF;
  endfunction

  function automatic int exp_state(input int n);
    if (n < INTRO_TICKS) return 0;
    if (n < SLIDE_END)   return 1;
    if (n < PLAY_TICK)   return 2;
    return 3;
  endfunction

  function automatic int exp_logo(input int n);
    int v;
    if (n <= INTRO_TICKS) return 0;
    v = -LOGO_STEP * (n - INTRO_TICKS);
    return (v < LOGO_END) ? LOGO_END : v;
  endfunction

  function automatic int exp_step(input int n);
    return (n > PLAY_TICK) ? (n - PLAY_TICK) % COIN_FRAMES : 0;
  endfunction

  always @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      m_ticks = 0; m_lane = 1; m_head_off = 0; exp_tick = 1'b0; vs_hist = '0;
    end else begin
      if (exp_tick) begin
        if (m_ticks >= PLAY_TICK) m_head_off = lane_off(m_lane);
        m_ticks++;
      end
      vs_hist  = {vs_hist[2:0], bus.VGA_VS};
      exp_tick = vs_hist[2] & ~vs_hist[3];
    end
  end

  always @(negedge CLK100MHZ) begin
    if (CPU_RESETN) begin
      check("m_frame_tick", int'(bus.frame_tick), int'(exp_tick));
      check("m_game_state", int'(bus.game_state), exp_state(m_ticks));
      check("m_logo_hoff",  int'(bus.logo_hoff),  exp_logo(m_ticks));
      check("m_head_voff",  int'(bus.head_voff),  (m_ticks >= PLAY_TICK) ? 0 : HEAD_START);
      check("m_head_hoff",  int'(bus.head_hoff),  m_head_off);
      check("m_coin_hoff",  int'(bus.coin_hoff),  -200 + exp_step(m_ticks));
      check("m_coin_voff",  int'(bus.coin_voff),  -40 - 6 * exp_step(m_ticks));
      check("m_coin_valid", int'(bus.coin_valid), (m_ticks > PLAY_TICK) ? 1 : 0);
    end
  end

  // Called at a negedge; the next posedge is the first to sample VS high.
  task automatic vsync_pulse();
    bus.VGA_VS = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge CLK100MHZ);
      check("tick_latency", int'(bus.frame_tick), (i == 3) ? 1 : 0);
    end
    bus.VGA_VS = 1'b0;
    repeat (6) @(negedge CLK100MHZ);
  endtask

  task automatic vsyncs(input int n);
    for (int i = 0; i < n; i++) vsync_pulse();
  endtask

  task automatic press(input bit l, input bit r);
    bus.BTNL = l;
    bus.BTNR = r;
    repeat (50) @(negedge CLK100MHZ);
    bus.BTNL = 1'b0;
    bus.BTNR = 1'b0;
    repeat (10) @(negedge CLK100MHZ);
    if (m_ticks >= PLAY_TICK && (l ^ r)) begin
      if (l) m_lane = (m_lane > 0) ? m_lane - 1 : 0;
      else   m_lane = (m_lane < 2) ? m_lane + 1 : 2;
    end
  endtask

  task automatic glitch_right();
    for (int i = 0; i < 3; i++) begin
      bus.BTNR = 1'b1;
      repeat (3) @(negedge CLK100MHZ);
      bus.BTNR = 1'b0;
      repeat (3) @(negedge CLK100MHZ);
    end
    repeat (10) @(negedge CLK100MHZ);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_tick"},  int'(bus.frame_tick), 0);
    check({tag, "_state"}, int'(bus.game_state), 0);
    check({tag, "_logo"},  int'(bus.logo_hoff),  0);
    check({tag, "_hhoff"}, int'(bus.head_hoff),  0);
    check({tag, "_hvoff"}, int'(bus.head_voff),  -170);
    check({tag, "_choff"}, int'(bus.coin_hoff),  -200);
    check({tag, "_cvoff"}, int'(bus.coin_voff),  -40);
    check({tag, "_valid"}, int'(bus.coin_valid), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.BTNL = 1'b0;
    bus.BTNR = 1'b0;
    bus.VGA_VS = 1'b0;
    repeat (3) @(negedge CLK100MHZ);
    CPU_RESETN = 1'b1;
    check_reset_values("rst0");

    press(1'b1, 1'b0);          // intro press must be discarded
    vsyncs(3);
    check("intro_state", int'(bus.game_state), 0);
    vsyncs(44);
    check("slide_state", int'(bus.game_state), 1);
    check("slide_logo",  int'(bus.logo_hoff), -300);

    @(negedge CLK100MHZ);
    #2 CPU_RESETN = 1'b0;
    #1 check_reset_values("rst_mid");
    repeat (2) @(negedge CLK100MHZ);
    CPU_RESETN = 1'b1;

    press(1'b0, 1'b1);          // also discarded, still in intro
    vsyncs(PLAY_TICK);
    check("play_state", int'(bus.game_state), 3);
    check("play_logo",  int'(bus.logo_hoff), -600);
    check("play_hvoff", int'(bus.head_voff), 0);

    vsync_pulse();              // first PLAY tick, step 1
    check("coin1_valid", int'(bus.coin_valid), 1);
    check("coin1_hoff",  int'(bus.coin_hoff), -199);
    check("coin1_voff",  int'(bus.coin_voff), -46);
    check("lane_intro",  int'(bus.head_hoff), 0);

    press(1'b1, 1'b0);
    vsync_pulse();
    check("lane_left",   int'(bus.head_hoff), 100);
    press(1'b1, 1'b0);
    vsync_pulse();
    check("lane_sat_l",  int'(bus.head_hoff), 100);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    vsync_pulse();
    check("lane_right",  int'(bus.head_hoff), -100);
    glitch_right();
    vsync_pulse();
    check("lane_glitch", int'(bus.head_hoff), -100);
    press(1'b1, 1'b0);
    vsync_pulse();
    check("lane_center", int'(bus.head_hoff), 0);
    press(1'b1, 1'b1);
    vsync_pulse();
    check("lane_both",   int'(bus.head_hoff), 0);

    // Step 7 reached so far; walk through the wrap.
    for (int s = 8; s <= 61; s++) begin
      vsync_pulse();
      if (s == 59) begin
        check("wrap59_voff", int'(bus.coin_voff), -394);
        check("wrap59_hoff", int'(bus.coin_hoff), -141);
      end
      if (s == 60) begin
        check("wrap0_voff",  int'(bus.coin_voff), -40);
        check("wrap0_hoff",  int'(bus.coin_hoff), -200);
        check("wrap0_valid", int'(bus.coin_valid), 1);
      end
    end
    check("final_state", int'(bus.game_state), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
